// File: rtl/mult16_seq_ctrl_pkg.sv
// Shared definitions for the sequenced 16x16 multiplier: FSM states,
// per-step shift constants, the step-to-half select table, and the
// mask / priority helpers used to walk the partial products.
package mult16_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Left shift applied to each partial product before accumulation.
  localparam logic [4:0] SH_K0 = 5'd0;
  localparam logic [4:0] SH_K1 = 5'd8;
  localparam logic [4:0] SH_K2 = 5'd8;
  localparam logic [4:0] SH_K3 = 5'd16;

  // One row of the step table: which operand halves feed the 8x8 core and
  // how far its result is shifted.
  typedef struct packed {
    logic       a_high;
    logic       x_high;
    logic [4:0] shift;
  } step_t;

  // Result of a priority search over the step mask.
  typedef struct packed {
    logic       found;
    logic [1:0] k;
  } pick_t;

  // Step table: k0 (AL,XL,0), k1 (AH,XL,8), k2 (AL,XH,8), k3 (AH,XH,16).
  function automatic step_t step_info(input logic [1:0] k);
    step_t s;
    case (k)
      2'd0:    s = '{a_high: 1'b0, x_high: 1'b0, shift: SH_K0};
      2'd1:    s = '{a_high: 1'b1, x_high: 1'b0, shift: SH_K1};
      2'd2:    s = '{a_high: 1'b0, x_high: 1'b1, shift: SH_K2};
      default: s = '{a_high: 1'b1, x_high: 1'b1, shift: SH_K3};
    endcase
    return s;
  endfunction

  // Selects the upper or lower byte of a 16-bit operand.
  function automatic logic [7:0] half_sel(input logic [15:0] v, input logic high);
    return high ? v[15:8] : v[7:0];
  endfunction

  // A step is needed unless zero-skipping is on and one of its input halves
  // is zero; a skipped step would only have added zero anyway.
  function automatic logic [3:0] build_mask(input logic [15:0] a,
                                            input logic [15:0] x,
                                            input logic        skip_zero);
    logic [3:0] m;
    step_t      s;
    m = 4'b1111;
    if (skip_zero) begin
      for (int i = 0; i < 4; i++) begin
        s = step_info(2'(i));
        if ((half_sel(a, s.a_high) == 8'h00) || (half_sel(x, s.x_high) == 8'h00)) begin
          m[i] = 1'b0;
        end
      end
    end
    return m;
  endfunction

  // Lowest set mask bit at or above 'from' (from may be 4, meaning none left).
  function automatic pick_t pick_step(input logic [3:0] mask, input logic [2:0] from);
    pick_t p;
    p.found = 1'b0;
    p.k     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) begin
        p.found = 1'b1;
        p.k     = 2'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mult16_seq_ctrl_mul8.sv
// Shared 8x8 multiplier core, purely combinational. This is the single
// instance that the sequencer time-multiplexes across all four steps.
module multiplier_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // Unsigned 8x8 product, widened before multiplying so no bits are lost.
  always_comb begin
    p = 16'(a) * 16'(b);
  end

endmodule

// File: rtl/mult16_seq_ctrl.sv
// Time-multiplexed 16x16 multiplier. One 8x8 core is stepped through the
// four partial products, which are shifted and summed into a 32-bit
// accumulator. Operands and result use valid/ready handshakes; with
// SKIP_ZERO set, steps whose operand half is zero are not executed.
module mult16_seq_ctrl
  import mult16_seq_ctrl_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] X,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] a_q, a_d;
  logic [15:0] x_q, x_d;
  logic [31:0] acc_q, acc_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;

  step_t       cur_step;
  logic [7:0]  mul_a;
  logic [7:0]  mul_x;
  logic [15:0] pp;
  logic [3:0]  new_mask;
  pick_t       first_pick;
  pick_t       next_pick;

  // Route the latched operand halves for the current step into the shared core.
  always_comb begin
    cur_step = step_info(k_q);
    mul_a    = half_sel(a_q, cur_step.a_high);
    mul_x    = half_sel(x_q, cur_step.x_high);
  end

  multiplier_8x8 u_mul8 (
    .a (mul_a),
    .b (mul_x),
    .p (pp)
  );

  // Step scheduling: the mask for a freshly offered operand pair, the first
  // step to run, and the step that follows the current one.
  always_comb begin
    new_mask   = build_mask(A, X, SKIP_ZERO);
    first_pick = pick_step(new_mask, 3'd0);
    next_pick  = pick_step(mask_q, {1'b0, k_q} + 3'd1);
  end

  // Next-state logic for the FSM, operand latches and accumulator; the
  // handshake outputs are derived from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    mask_d  = mask_q;
    a_d     = a_q;
    x_d     = x_q;
    acc_d   = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d    = A;
          x_d    = X;
          acc_d  = 32'd0;
          mask_d = new_mask;
          if (first_pick.found) begin
            state_d = ST_MUL;
            k_d     = first_pick.k;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        acc_d = acc_q + ({16'b0, pp} << cur_step.shift);
        if (next_pick.found) begin
          k_d = next_pick.k;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State register; reset aborts any operation in flight and discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= 2'd0;
      mask_q      <= 4'd0;
      a_q         <= 16'd0;
      x_q         <= 16'd0;
      acc_q       <= 32'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      mask_q      <= mask_d;
      a_q         <= a_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign product   = acc_q;

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Bench for the sequenced 16x16 multiplier. Two instances share the clock,
// reset and operand buses: dut0 without zero-skipping, dut1 with it.
module tb_mult16_seq_ctrl;

  typedef struct {
    int          sel;
    logic [15:0] a;
    logic [15:0] x;
    logic [31:0] prod;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_in;
  logic [15:0] x_in;
  logic [1:0]  in_valid;
  logic [1:0]  out_ready;
  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [1:0]  busy;
  logic [31:0] product [2];

  int checks;
  int failures;
  int overlap;

  vec_t vecs [13];

  mult16_seq_ctrl #(.SKIP_ZERO(1'b0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .A         (a_in),
    .X         (x_in),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .product   (product[0]),
    .busy      (busy[0])
  );

  mult16_seq_ctrl #(.SKIP_ZERO(1'b1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .A         (a_in),
    .X         (x_in),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .product   (product[1]),
    .busy      (busy[1])
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // in_ready and busy must never be high together on either instance.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i] && in_ready[i]) overlap++;
    end
  end

  // Hard stop in case something stalls beyond every bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one value and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Offer one operand pair, then wait (bounded) for the result.
  // lat counts edges from the acceptance edge up to out_valid high.
  task automatic applyStimulus(input int sel, input logic [15:0] a, input logic [15:0] x,
                               output int lat, output logic [31:0] prod);
    @(negedge clk);
    a_in          = a;
    x_in          = x;
    in_valid[sel] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    lat = 1;
    while (!out_valid[sel] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    prod = product[sel];
  endtask

  // Hold off the consumer for some cycles, then accept for one edge.
  task automatic releaseResult(input int sel, input int hold);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    out_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[sel] = 1'b0;
  endtask

  initial begin
    int          lat;
    int          bad;
    logic [31:0] prod;
    logic [15:0] ra;
    logic [15:0] rx;
    int          rsel;

    checks    = 0;
    failures  = 0;
    overlap   = 0;
    rst_n     = 1'b0;
    a_in      = 16'd0;
    x_in      = 16'd0;
    in_valid  = 2'b00;
    out_ready = 2'b00;

    vecs[0]  = '{0, 16'h0101, 16'h0202, 32'h0002_0402, 5};
    vecs[1]  = '{0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 5};
    vecs[2]  = '{0, 16'h0000, 16'h1234, 32'h0000_0000, 5};
    vecs[3]  = '{0, 16'h1234, 16'h5678, 32'h0626_0060, 5};
    vecs[4]  = '{0, 16'h8000, 16'h8000, 32'h4000_0000, 5};
    vecs[5]  = '{1, 16'h00FF, 16'h00FF, 32'h0000_FE01, 2};
    vecs[6]  = '{1, 16'h0000, 16'h1234, 32'h0000_0000, 1};
    vecs[7]  = '{1, 16'hFF00, 16'h00FF, 32'h00FE_0100, 2};
    vecs[8]  = '{1, 16'h00FF, 16'hFF00, 32'h00FE_0100, 2};
    vecs[9]  = '{1, 16'h0100, 16'h0100, 32'h0001_0000, 2};
    vecs[10] = '{1, 16'h0101, 16'h0100, 32'h0001_0100, 3};
    vecs[11] = '{1, 16'h1234, 16'h5678, 32'h0626_0060, 5};
    vecs[12] = '{1, 16'h0000, 16'h0000, 32'h0000_0000, 1};

    // Reset state, both while reset is held and just after release.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid[0]), 32'd0);
    checkOutput("rst_product", product[0], 32'd0);
    checkOutput("rst_busy", 32'(busy[0]), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", 32'({in_ready[1], in_ready[0]}), 32'd3);
    checkOutput("post_rst_out_valid", 32'({out_valid[1], out_valid[0]}), 32'd0);

    // Directed table: product and latency for each vector.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].a, vecs[i].x, lat, prod);
      checkOutput($sformatf("vec%0d_product", i), prod, vecs[i].prod);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      releaseResult(vecs[i].sel, i % 3);
      checkOutput($sformatf("vec%0d_released", i), 32'(out_valid[vecs[i].sel]), 32'd0);
    end

    // Backpressure: result held for 10 cycles, then a single out_ready edge.
    applyStimulus(0, 16'h0003, 16'h0005, lat, prod);
    checkOutput("bp_product", prod, 32'd15);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!out_valid[0] || product[0] !== 32'd15 || in_ready[0]) bad++;
    end
    checkOutput("bp_hold_stable", 32'(bad), 32'd0);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    checkOutput("bp_out_valid_dropped", 32'(out_valid[0]), 32'd0);
    checkOutput("bp_in_ready_back", 32'(in_ready[0]), 32'd1);
    checkOutput("bp_product_kept", product[0], 32'd15);

    // Operand changes and in_valid during MUL must be ignored.
    @(negedge clk);
    a_in        = 16'h1111;
    x_in        = 16'h0011;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      a_in = (i % 2 == 0) ? 16'hFFFF : 16'hA5A5;
      x_in = (i % 2 == 0) ? 16'hFFFF : 16'h5A5A;
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid[0] = 1'b0;
    while (!out_valid[0] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("ignore_product", product[0], 32'h0001_2221);
    checkOutput("ignore_latency", 32'(lat), 32'd5);

    // in_valid and out_ready together in DONE: only the release happens.
    a_in         = 16'h0002;
    x_in         = 16'h0003;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    checkOutput("both_high_not_accepted", 32'(busy[0]), 32'd0);
    checkOutput("both_high_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    checkOutput("both_high_later_accept", 32'(busy[0]), 32'd1);
    lat = 1;
    while (!out_valid[0] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("both_high_product", product[0], 32'd6);
    releaseResult(0, 0);

    // Reset during step k2 aborts the operation with no result.
    applyStimulus(0, 16'h0000, 16'h0000, lat, prod);
    releaseResult(0, 0);
    @(negedge clk);
    a_in        = 16'h1234;
    x_in        = 16'h5678;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid[0]), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready[0]), 32'd1);
    checkOutput("abort_busy", 32'(busy[0]), 32'd0);
    checkOutput("abort_product", product[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid[0] || busy[0]) bad++;
    end
    checkOutput("abort_no_pulse", 32'(bad), 32'd0);
    applyStimulus(0, 16'hFFFF, 16'h0001, lat, prod);
    checkOutput("after_abort_product", prod, 32'h0000_FFFF);
    checkOutput("after_abort_latency", 32'(lat), 32'd5);
    releaseResult(0, 1);

    // Random operands (with frequent zero halves) and random backpressure.
    for (int i = 0; i < 200; i++) begin
      rsel = i % 2;
      ra   = 16'($urandom);
      rx   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra[7:0]  = 8'h00;
      if ($urandom_range(0, 3) == 0) ra[15:8] = 8'h00;
      if ($urandom_range(0, 3) == 0) rx[7:0]  = 8'h00;
      if ($urandom_range(0, 3) == 0) rx[15:8] = 8'h00;
      applyStimulus(rsel, ra, rx, lat, prod);
      checkOutput($sformatf("rand%0d_%0h_x_%0h", i, ra, rx), prod, 32'(ra) * 32'(rx));
      releaseResult(rsel, int'($urandom_range(0, 3)));
    end

    checkOutput("ready_busy_exclusive", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
